// File: rtl/pixel_filter_pipe.sv
// Four-stage registered pixel filter: ordered-dither quantise, greyscale, channel
// permutation and invert, with delay-matched sync sidebands and frame-locked mode.
module pixel_filter_pipe #(
  parameter int         IW            = 8,
  parameter int         CW            = 4,
  parameter int         XW            = 11,
  parameter int         YW            = 11,
  parameter bit         VS_ACTIVE_LOW = 1'b1,
  parameter logic [7:0] MODE_RST      = 8'h00
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [3*IW-1:0] pix_in,
  input  logic            pix_valid,
  input  logic [XW-1:0]   pos_x,
  input  logic [YW-1:0]   pos_y,
  input  logic            hsync_in,
  input  logic            vsync_in,
  input  logic [7:0]      mode_in,
  output logic [3*CW-1:0] pix_out,
  output logic            pix_out_valid,
  output logic            hsync_out,
  output logic            vsync_out,
  output logic [7:0]      mode_active
);

  localparam int   K         = IW - CW;
  localparam int   GW        = CW + 9;
  localparam logic SYNC_IDLE = VS_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [3:0]      bayer;
  logic [IW-1:0]   offset;
  logic [3*CW-1:0] q1;
  logic [3*K-1:0]  drop1;
  logic            vs_prev;
  logic            vs_edge;

  logic [3*CW-1:0] s1_pix, s2_pix, s3_pix, p3;
  logic [5:0]      s1_mode;
  logic [4:0]      s2_mode;
  logic            s3_inv;
  logic [3:0]      valid_sr, hs_sr, vs_sr;

  logic [GW-1:0]   y_sum;
  logic [CW-1:0]   y_val;
  logic [CW-1:0]   r2, g2, b2;

  always_comb begin
    bayer = 4'd0;
    case ({pos_y[1:0], pos_x[1:0]})
      4'h0: bayer = 4'd0;   4'h1: bayer = 4'd8;   4'h2: bayer = 4'd2;   4'h3: bayer = 4'd10;
      4'h4: bayer = 4'd12;  4'h5: bayer = 4'd4;   4'h6: bayer = 4'd14;  4'h7: bayer = 4'd6;
      4'h8: bayer = 4'd3;   4'h9: bayer = 4'd11;  4'hA: bayer = 4'd1;   4'hB: bayer = 4'd9;
      4'hC: bayer = 4'd15;  4'hD: bayer = 4'd7;   4'hE: bayer = 4'd13;  4'hF: bayer = 4'd5;
      default: bayer = 4'd0;
    endcase
  end

  // Scale the 0..15 threshold so it spans exactly the bits discarded by quantisation.
  if (K >= 4) begin : g_off_up
    assign offset = IW'(bayer) << (K - 4);
  end else begin : g_off_dn
    assign offset = IW'(bayer >> (4 - K));
  end

  for (genvar c = 0; c < 3; c++) begin : g_quant
    logic [IW-1:0] ch, dv;
    logic [IW:0]   sum;
    assign ch  = pix_in[c*IW +: IW];
    assign sum = {1'b0, ch} + {1'b0, offset};
    assign dv  = mode_active[0] ? (sum[IW] ? {IW{1'b1}} : sum[IW-1:0]) : ch;
    assign q1[c*CW +: CW]  = dv[IW-1 -: CW];
    assign drop1[c*K +: K] = dv[K-1:0];
  end

  // Mode is captured only on the vsync assertion edge so a frame never mixes settings.
  assign vs_edge = (vsync_in != SYNC_IDLE) && (vs_prev == SYNC_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_prev     <= SYNC_IDLE;
      mode_active <= MODE_RST;
    end else begin
      vs_prev <= vsync_in;
      if (vs_edge) mode_active <= mode_in;
    end
  end

  assign r2 = s1_pix[3*CW-1 -: CW];
  assign g2 = s1_pix[2*CW-1 -: CW];
  assign b2 = s1_pix[CW-1:0];
  assign y_sum = GW'(r2) * GW'(77) + GW'(g2) * GW'(150) + GW'(b2) * GW'(29);
  assign y_val = y_sum[CW+7:8];

  always_comb begin
    logic [CW-1:0] r, g, b;
    r  = s2_pix[3*CW-1 -: CW];
    g  = s2_pix[2*CW-1 -: CW];
    b  = s2_pix[CW-1:0];
    p3 = s2_pix;
    if (s2_mode[0]) begin
      case (s2_mode[4:2])
        3'd1:    p3 = {r, b, g};
        3'd2:    p3 = {g, r, b};
        3'd3:    p3 = {g, b, r};
        3'd4:    p3 = {b, r, g};
        3'd5:    p3 = {b, g, r};
        default: p3 = {r, g, b};
      endcase
    end
  end

  // Each pixel carries the mode bits it was quantised with down the pipe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_pix   <= '0;
      s1_mode  <= '0;
      s2_pix   <= '0;
      s2_mode  <= '0;
      s3_pix   <= '0;
      s3_inv   <= 1'b0;
      pix_out  <= '0;
      valid_sr <= '0;
      hs_sr    <= {4{SYNC_IDLE}};
      vs_sr    <= {4{SYNC_IDLE}};
    end else begin
      s1_pix   <= q1;
      s1_mode  <= mode_active[6:1];
      s2_pix   <= s1_mode[0] ? {3{y_val}} : s1_pix;
      s2_mode  <= s1_mode[5:1];
      s3_pix   <= p3;
      s3_inv   <= s2_mode[1];
      pix_out  <= !valid_sr[2] ? '0 : (s3_inv ? ~s3_pix : s3_pix);
      valid_sr <= {valid_sr[2:0], pix_valid};
      hs_sr    <= {hs_sr[2:0], hsync_in};
      vs_sr    <= {vs_sr[2:0], vsync_in};
    end
  end

  assign pix_out_valid = valid_sr[3];
  assign hsync_out     = hs_sr[3];
  assign vsync_out     = vs_sr[3];

  logic unused_bits;
  assign unused_bits = ^{pos_x[XW-1:2], pos_y[YW-1:2], mode_active[7], drop1,
                         y_sum[GW-1:CW+8], y_sum[7:0]};

endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Testbench for pixel_filter_pipe: directed and random pixels checked against an
// arithmetic reference model with a 4-deep expectation queue.
module tb_pixel_filter_pipe;

  localparam int IW = 8;
  localparam int CW = 4;
  localparam int XW = 11;
  localparam int YW = 11;
  localparam int K  = IW - CW;

  logic            clk = 1'b0;
  logic            resetn;
  logic [3*IW-1:0] pix_in;
  logic            pix_valid;
  logic [XW-1:0]   pos_x;
  logic [YW-1:0]   pos_y;
  logic            hsync_in, vsync_in;
  logic [7:0]      mode_in;
  logic [3*CW-1:0] pix_out;
  logic            pix_out_valid, hsync_out, vsync_out;
  logic [7:0]      mode_active;

  typedef struct packed {
    logic [3*CW-1:0] pix;
    logic            valid;
    logic            hs;
    logic            vs;
  } exp_t;

  exp_t       expQ[$];
  logic [7:0] modeModel;
  logic       prevVs;
  logic [7:0] modeDrive;
  int         testCount = 0;
  int         failCount = 0;

  int bayerTab[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
  int permTab[8][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0},
                        '{2,0,1}, '{2,1,0}, '{0,1,2}, '{0,1,2}};

  pixel_filter_pipe #(.IW(IW), .CW(CW), .XW(XW), .YW(YW),
                      .VS_ACTIVE_LOW(1'b1), .MODE_RST(8'h00)) dut (
    .clk(clk), .resetn(resetn), .pix_in(pix_in), .pix_valid(pix_valid),
    .pos_x(pos_x), .pos_y(pos_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mode_in(mode_in), .pix_out(pix_out), .pix_out_valid(pix_out_valid),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  function automatic logic [3*CW-1:0] refPixel(logic [3*IW-1:0] p, int x, int y, logic [7:0] m);
    int ch[3], q[3], o[3];
    int t, off, v, yv;
    int maxIn = (1 << IW) - 1;
    int maxC  = (1 << CW) - 1;
    t   = bayerTab[(y % 4) * 4 + (x % 4)];
    off = (K >= 4) ? (t << (K - 4)) : (t >> (4 - K));
    for (int i = 0; i < 3; i++) begin
      ch[i] = int'((p >> ((2 - i) * IW)) & maxIn);
      v     = m[0] ? ((ch[i] + off > maxIn) ? maxIn : ch[i] + off) : ch[i];
      q[i]  = v >> K;
    end
    if (m[1]) begin
      yv = (77 * q[0] + 150 * q[1] + 29 * q[2]) / 256;
      for (int i = 0; i < 3; i++) q[i] = yv;
    end
    for (int i = 0; i < 3; i++) o[i] = m[2] ? q[permTab[m[6:4]][i]] : q[i];
    if (m[3]) for (int i = 0; i < 3; i++) o[i] = maxC - o[i];
    return {CW'(o[0]), CW'(o[1]), CW'(o[2])};
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    testCount++;
    assert (got === want) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkVal("pix_out", 32'(pix_out), 32'(e.pix));
    checkVal("pix_out_valid", 32'(pix_out_valid), 32'(e.valid));
    checkVal("hsync_out", 32'(hsync_out), 32'(e.hs));
    checkVal("vsync_out", 32'(vsync_out), 32'(e.vs));
    checkVal("mode_active", 32'(mode_active), 32'(modeModel));
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_pix"}, 32'(pix_out), 32'h0);
    checkVal({tag, "_valid"}, 32'(pix_out_valid), 32'h0);
    checkVal({tag, "_hs"}, 32'(hsync_out), 32'h1);
    checkVal({tag, "_vs"}, 32'(vsync_out), 32'h1);
    checkVal({tag, "_mode"}, 32'(mode_active), 32'h0);
  endtask

  task automatic resetModel();
    exp_t e;
    e = '{pix: '0, valid: 1'b0, hs: 1'b1, vs: 1'b1};
    expQ.delete();
    repeat (3) expQ.push_back(e);
    modeModel = 8'h00;
    prevVs    = 1'b1;
  endtask

  task automatic applyStimulus(input logic [3*IW-1:0] p, input logic v, input int x, input int y,
                               input logic hs, input logic vs, input logic [7:0] m);
    exp_t e;
    @(negedge clk);
    pix_in = p; pix_valid = v; pos_x = XW'(x); pos_y = YW'(y);
    hsync_in = hs; vsync_in = vs; mode_in = m;
    @(posedge clk);
    e.pix   = v ? refPixel(p, x, y, modeModel) : '0;
    e.valid = v; e.hs = hs; e.vs = vs;
    expQ.push_back(e);
    if (vs == 1'b0 && prevVs == 1'b1) modeModel = m;
    prevVs = vs;
    e = expQ.pop_front();
    #1 checkOutput(e);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus('0, 1'b0, 0, 0, 1'b1, 1'b1, modeDrive);
  endtask

  task automatic setMode(input logic [7:0] m);
    modeDrive = m;
    applyStimulus('0, 1'b0, 0, 0, 1'b1, 1'b0, m);
    applyStimulus('0, 1'b0, 0, 0, 1'b1, 1'b1, m);
  endtask

  task automatic directedPixel(input string tag, input logic [3*IW-1:0] p, input int x, input int y,
                               input logic [3*CW-1:0] want);
    applyStimulus(p, 1'b1, x, y, 1'b1, 1'b1, modeDrive);
    idle(3);
    checkVal(tag, 32'(pix_out), 32'(want));
  endtask

  initial begin
    logic vsRand;
    resetn = 1'b0; modeDrive = 8'h00;
    pix_in = '0; pix_valid = 1'b0; pos_x = '0; pos_y = '0;
    hsync_in = 1'b1; vsync_in = 1'b1; mode_in = 8'h00;

    // Reset held with toggling inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pix_in = 24'($urandom); pix_valid = 1'($urandom); hsync_in = 1'($urandom);
      vsync_in = 1'($urandom); mode_in = 8'($urandom);
      @(posedge clk);
      #1 checkResetState("reset_hold");
    end
    #1 resetn = 1'b1;
    resetModel();

    idle(2);
    applyStimulus(24'h123456, 1'b1, 0, 0, 1'b1, 1'b1, modeDrive);
    idle(2);
    checkVal("valid_lat3", 32'(pix_out_valid), 32'h0);
    idle(1);
    checkVal("valid_lat4", 32'(pix_out_valid), 32'h1);

    // Plain truncation with an hsync pulse travelling alongside
    setMode(8'h00);
    applyStimulus(24'hABCDEF, 1'b1, 0, 0, 1'b0, 1'b1, modeDrive);
    idle(3);
    checkVal("trunc_ace", 32'(pix_out), 32'hACE);
    checkVal("hsync_delay", 32'(hsync_out), 32'h0);

    setMode(8'h01);
    directedPixel("dither_x0y0", 24'h181818, 0, 0, 12'h111);
    directedPixel("dither_x1y0", 24'h181818, 1, 0, 12'h222);
    directedPixel("dither_sat", 24'hFFFFFF, 0, 3, 12'hFFF);

    setMode(8'h02);
    directedPixel("grey_red", 24'hF00000, 0, 0, 12'h444);
    directedPixel("grey_flat", 24'h707070, 0, 0, 12'h777);

    setMode(8'h34);
    directedPixel("perm_gbr", 24'h102030, 0, 0, 12'h231);
    setMode(8'h08);
    directedPixel("invert", 24'h102030, 0, 0, 12'hEDC);
    setMode(8'h64);
    directedPixel("perm_sel6", 24'h102030, 0, 0, 12'h123);

    // Shadowing: mode_in changes without vsync must be ignored
    setMode(8'h00);
    modeDrive = 8'h08;
    for (int i = 0; i < 6; i++) applyStimulus(24'h102030, 1'b1, i, 0, 1'b1, 1'b1, 8'h08);
    checkVal("shadow_mode", 32'(mode_active), 32'h00);
    checkVal("shadow_pix", 32'(pix_out), 32'h123);
    applyStimulus(24'h102030, 1'b1, 0, 0, 1'b1, 1'b0, 8'h08);
    applyStimulus(24'h102030, 1'b1, 1, 0, 1'b1, 1'b0, 8'h08);
    idle(2);
    checkVal("edge_pixel_old", 32'(pix_out), 32'h123);
    idle(1);
    checkVal("next_pixel_inv", 32'(pix_out), 32'hEDC);

    // Asynchronous reset mid-line with pixels in flight
    for (int i = 0; i < 5; i++) applyStimulus(24'h102030, 1'b1, i, 1, 1'b1, 1'b1, 8'h08);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 checkResetState("async_reset");
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    resetModel();
    modeDrive = 8'h00;

    // Random traffic with occasional frame starts carrying random modes
    vsRand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) vsRand = ~vsRand;
      applyStimulus(24'($urandom), ($urandom_range(0, 3) != 0), $urandom_range(0, 2047),
                    $urandom_range(0, 2047), 1'($urandom), vsRand, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
